// File: rtl/board_led_scanner_if.sv
// Display-side bundle between the connect-four datapath and the LED matrix scanner.
// master = board state producer / LED consumer, slave = the scanner.
interface board_led_scanner_if;
    logic [15:0] gameboard;
    logic [15:0] player_cells;
    logic [1:0]  game_status;
    logic [3:0]  row_sel;
    logic [3:0]  col_red;
    logic [3:0]  col_green;
    logic        frame_start;

    modport master (
        output gameboard,
        output player_cells,
        output game_status,
        input  row_sel,
        input  col_red,
        input  col_green,
        input  frame_start
    );

    modport slave (
        input  gameboard,
        input  player_cells,
        input  game_status,
        output row_sel,
        output col_red,
        output col_green,
        output frame_start
    );
endinterface

// File: rtl/board_led_scanner.sv
// Time-multiplexed 4x4 bicolour LED scanner with per-frame board snapshot and win/draw blink.
// Optional macro SCAN_BLANKING_EN blanks row/column drive for the first TICK_DIV/8 clocks of each row.
module board_led_scanner #(
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                clk,
    input  logic                reset,
    board_led_scanner_if.slave  bus
);

    localparam int unsigned CELLS  = 16;
    localparam int unsigned COLS   = 4;
    localparam int unsigned ROW_W  = 2;
    localparam int unsigned PCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(TICK_DIV - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_FRAMES - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(3);

    localparam logic [1:0] ST_P1_WON = 2'b01;
    localparam logic [1:0] ST_P2_WON = 2'b10;
    localparam logic [1:0] ST_DRAW   = 2'b11;

    logic [PCNT_W-1:0] pcnt;
    logic [ROW_W-1:0]  row;
    logic [BCNT_W-1:0] bcnt;
    logic              blink_phase;
    logic              live;
    logic [CELLS-1:0]  sh_board;
    logic [CELLS-1:0]  sh_owner;
    logic [1:0]        sh_status;

    logic              tick_c;
    logic              frame_edge_c;
    logic              blank_c;
    logic              vis_red_c;
    logic              vis_green_c;
    logic [CELLS-1:0]  red_cells_c;
    logic [CELLS-1:0]  green_cells_c;
    logic [COLS-1:0]   row_red_c;
    logic [COLS-1:0]   row_green_c;

    assign tick_c       = (pcnt == PCNT_LAST);
    assign frame_edge_c = tick_c && (row == ROW_LAST);

`ifdef SCAN_BLANKING_EN
    localparam logic [PCNT_W-1:0] BLANK_LEN = PCNT_W'(TICK_DIV / 8);
    assign blank_c = (pcnt < BLANK_LEN);
`else
    assign blank_c = 1'b0;
`endif

    // Visible mask and active-row column data, derived from the snapshot only
    always_comb begin
        vis_red_c     = 1'b1;
        vis_green_c   = 1'b1;
        red_cells_c   = sh_board & ~sh_owner;
        green_cells_c = sh_board & sh_owner;
        if (blink_phase) begin
            if (sh_status == ST_P1_WON || sh_status == ST_DRAW) begin
                vis_red_c = 1'b0;
            end
            if (sh_status == ST_P2_WON || sh_status == ST_DRAW) begin
                vis_green_c = 1'b0;
            end
        end
        row_red_c   = red_cells_c[{row, 2'b00} +: COLS] & {COLS{vis_red_c}};
        row_green_c = green_cells_c[{row, 2'b00} +: COLS] & {COLS{vis_green_c}};
    end

    // Prescaler, row scan, frame snapshot, blink timer and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt            <= '0;
            row             <= ROW_LAST;
            bcnt            <= '0;
            blink_phase     <= 1'b0;
            live            <= 1'b0;
            sh_board        <= '0;
            sh_owner        <= '0;
            sh_status       <= '0;
            bus.row_sel     <= '0;
            bus.col_red     <= '0;
            bus.col_green   <= '0;
            bus.frame_start <= 1'b0;
        end else begin
            pcnt <= tick_c ? '0 : pcnt + PCNT_W'(1);

            if (tick_c) begin
                row  <= row + ROW_W'(1);
                live <= 1'b1;
            end

            if (frame_edge_c) begin
                sh_board  <= bus.gameboard;
                sh_owner  <= bus.player_cells;
                sh_status <= bus.game_status;
                if (bcnt == BCNT_LAST) begin
                    bcnt        <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    bcnt <= bcnt + BCNT_W'(1);
                end
            end

            // Output stage lags the counters by one clock; row 0 entry is pcnt==0 with row==0
            bus.frame_start <= live && (row == '0) && (pcnt == '0);

            if (!live || blank_c) begin
                bus.row_sel   <= '0;
                bus.col_red   <= '0;
                bus.col_green <= '0;
            end else begin
                bus.row_sel   <= COLS'(1) << row;
                bus.col_red   <= row_red_c;
                bus.col_green <= row_green_c;
            end
        end
    end

endmodule

// File: doc/board_led_scanner.md
# board_led_scanner

Downstream display stage of the connect-four datapath. It consumes the 16-cell occupancy map (`gameboard_out`), the owner map (`player_cells`) and the winner status (`game_status`), and drives a time-multiplexed 4x4 bicolour LED matrix. Board state is snapshotted once per frame so a move landing mid-scan never tears the picture. Cells blink to flag a win or a draw.

## Interface
Parameters:
- `TICK_DIV`, default 50000: clocks per row period (1 kHz row rate at 50 MHz). Legal minimum is 8.
- `BLINK_FRAMES`, default 64: frames per blink half-period. Legal minimum is 1.

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: one clock; reset is synchronous and active-high.
- `gameboard`  in  16: cell occupied flags. Index = row*4 + col.
- `player_cells`  in  16: cell owner. 0 = player 1 (red), 1 = player 2 (green). Ignored where the cell is unoccupied.
- `game_status`  in  2: 00 playing, 01 player 1 won, 10 player 2 won, 11 draw.
- `row_sel`  out  4: one-hot active row, active-high.
- `col_red`  out  4: red column drive for the active row. Bit c = column c.
- `col_green`  out  4: green column drive for the active row.
- `frame_start`  out  1: one-cycle pulse when row 0 becomes active.

## Operation
- Prescaler `pcnt` counts 0..TICK_DIV-1 and wraps. A tick is the edge where `pcnt == TICK_DIV-1`.
- Row counter `row` (2 bits) increments on each tick, wrapping 3→0.
- Frame boundary is a tick where `row` goes 3→0. On that edge:
  - `gameboard`, `player_cells` and `game_status` are captured into shadow registers.
  - Blink counter `bcnt` (0..BLINK_FRAMES-1) increments. On wrap, `blink_phase` toggles.
- Visible mask, computed from shadow values only:
  - Playing: every occupied cell is lit.
  - Status 01: red cells are lit only when `blink_phase == 0`; green cells stay steady.
  - Status 10: the same rule applied to green cells; red cells stay steady.
  - Status 11: all occupied cells are lit only when `blink_phase == 0`.
- Output composition for the active row r:
  - `col_red[c]` = occ & ~owner & visible.
  - `col_green[c]` = occ & owner & visible.
  - `row_sel` = 1 << r.
- All outputs are registered.
- Inputs are never used directly for display. Changes take effect only at the next frame boundary.
- Reset clears the following:
  - `pcnt` = 0, `row` = 3 (so the first tick enters row 0 and captures a snapshot).
  - All shadow registers = 0, `bcnt` = 0, `blink_phase` = 0.
  - Outputs: `row_sel` = 0000, `col_red` = 0000, `col_green` = 0000, `frame_start` = 0.
- `row_sel` stays 0000 until the first tick.
- Reset asserted mid-frame forces the reset values on the next edge. No partial frame completes.

## Timing
- The first tick occurs on the TICK_DIV-th edge after reset deasserts.
- Row 0 outputs and the `frame_start` pulse appear one clock after that tick edge (registered output stage). They are therefore visible from edge TICK_DIV+1.
- Each row is held for exactly TICK_DIV clocks. A frame lasts 4*TICK_DIV clocks.
- `frame_start` is high for exactly one clock per frame.
- Input-to-display latency runs from the input change to the next frame boundary, plus one clock. Worst case is 4*TICK_DIV+1 clocks.
- The blink state changes only at frame boundaries. A full blink period is 2*BLINK_FRAMES frames.
- Input changes arriving on the same edge as the frame-boundary tick are captured.

## Configuration
- `SCAN_BLANKING_EN`
  - Defined: for the first TICK_DIV/8 clocks of every row period (the window where `pcnt` < TICK_DIV/8, evaluated one clock later at the output registers), `row_sel`, `col_red` and `col_green` are forced to 0000. This removes ghosting. `frame_start` timing is unchanged.
  - Undefined: the row and column outputs are driven for the full row period.

## Test plan
Bench settings: TICK_DIV=8, BLINK_FRAMES=2, macro undefined unless stated.

- **Reset:** hold `reset` for 3 clocks, then release → all outputs 0 for 8 clocks. Then `row_sel`=0001 and `frame_start`=1 for 1 clock. `row_sel` steps 0010, 0100, 1000 every 8 clocks.
- **Colour mapping:** `gameboard`=16'h8001, `player_cells`=16'h8000 → row 0 shows `col_red`=0001, `col_green`=0000. Row 3 shows `col_red`=0000, `col_green`=1000.
- **Snapshot isolation:** with row 1 active, change `gameboard` from 16'h0001 to 16'h0010 → row 1 columns stay 0000 in the current frame. In the next frame row 1 shows `col_red`=0001 and row 0 shows 0000.
- **Win blink:** `game_status`=01, `gameboard`=16'h0003, `player_cells`=16'h0002 → row 0 `col_red` alternates 0001 (2 frames) and 0000 (2 frames). `col_green`=0010 stays steady.
- **Draw blink:** `game_status`=11 on a full board → both colours go to 0000 during `blink_phase`=1 frames, then restore.
- **Blanking:** with `SCAN_BLANKING_EN` defined → each row outputs 0000 on `row_sel`, `col_red` and `col_green` for the first clock of its 8-clock period, then the normal values. With `reset` asserted mid-row, all outputs are 0 on the next edge.
